// File: rtl/chebyshev_clenshaw_seq.sv
// Sequential Chebyshev series evaluator (Clenshaw recurrence, one multiply per cycle).
// Define CHEBYSHEV_CLENSHAW_SAT_EN to build saturating arithmetic with a sticky ovf flag.
module chebyshev_clenshaw_seq #(
  parameter int unsigned WL       = 16,
  parameter int unsigned CL       = 16,
  parameter int unsigned DEGREE   = 4,
  parameter int unsigned WIDENING = 3,
  parameter int unsigned AW       = $clog2(DEGREE + 1)
) (
  input  logic                              clock,
  input  logic                              reset,
  input  logic                              coeff_we,
  input  logic [AW-1:0]                     coeff_addr,
  input  logic signed [CL-1:0]              coeff_in,
  input  logic                              in_valid,
  output logic                              in_ready,
  input  logic signed [WL-1:0]              data_in,
  output logic                              out_valid,
  input  logic                              out_ready,
  output logic signed [CL+WIDENING+1:0]     data_out,
  output logic                              ovf
);

  localparam int unsigned ACC_W = CL + WIDENING + 2;
  localparam int unsigned PW    = ACC_W + WL;
  localparam int unsigned RW    = ACC_W + 1;
  localparam int unsigned SW    = ACC_W + 3;
  localparam int unsigned NC    = DEGREE + 1;

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_e;

  state_e                   state_q, state_d;
  logic                     in_ready_q, in_ready_d;
  logic                     out_valid_q, out_valid_d;
  logic signed [ACC_W-1:0]  data_out_q, data_out_d;
  logic signed [ACC_W-1:0]  b1_q, b1_d;
  logic signed [ACC_W-1:0]  b2_q, b2_d;
  logic signed [WL-1:0]     x_q, x_d;
  logic [AW-1:0]            k_q, k_d;
  logic signed [CL-1:0]     bank_q [NC];
  logic signed [CL-1:0]     bank_d [NC];
`ifdef CHEBYSHEV_CLENSHAW_SAT_EN
  logic                     ovf_q, ovf_d;
  logic                     clip;
`endif

  logic signed [PW-1:0]     prod;
  logic signed [PW-1:0]     prod_rnd;
  logic signed [RW-1:0]     r;
  logic signed [SW-1:0]     term;
  logic signed [SW-1:0]     sum;
  logic signed [ACC_W-1:0]  res;

  // One Clenshaw step: doubled rounded product for k >= 1, plain product for the final k = 0
  always_comb begin : datapath
    prod     = PW'(b1_q) * PW'(x_q);
    prod_rnd = prod + (PW'(1) <<< (WL - 2));
    r        = RW'(prod_rnd >>> (WL - 1));
    term     = (k_q != '0) ? (SW'(r) <<< 1) : SW'(r);
    sum      = term - SW'(b2_q) + SW'(bank_q[k_q]);
`ifdef CHEBYSHEV_CLENSHAW_SAT_EN
    clip = (sum[SW-1:ACC_W-1] != '0) && (sum[SW-1:ACC_W-1] != '1);
    if (clip) begin
      res = sum[SW-1] ? {1'b1, {(ACC_W-1){1'b0}}} : {1'b0, {(ACC_W-1){1'b1}}};
    end else begin
      res = sum[ACC_W-1:0];
    end
`else
    res = ACC_W'(sum);
`endif
  end

  always_comb begin : next_state
    state_d     = state_q;
    in_ready_d  = in_ready_q;
    out_valid_d = out_valid_q;
    data_out_d  = data_out_q;
    b1_d        = b1_q;
    b2_d        = b2_q;
    x_d         = x_q;
    k_d         = k_q;
    bank_d      = bank_q;
`ifdef CHEBYSHEV_CLENSHAW_SAT_EN
    ovf_d       = ovf_q;
`endif
    unique case (state_q)
      IDLE: begin
        // Bank write lands before the first CALC read, so a same-cycle accept sees it
        if (coeff_we && (32'(coeff_addr) <= 32'(DEGREE))) begin
          bank_d[coeff_addr] = coeff_in;
        end
        if (in_valid && in_ready_q) begin
          x_d        = data_in;
          b1_d       = '0;
          b2_d       = '0;
          k_d        = AW'(DEGREE);
          in_ready_d = 1'b0;
          state_d    = CALC;
`ifdef CHEBYSHEV_CLENSHAW_SAT_EN
          ovf_d      = 1'b0;
`endif
        end
      end
      CALC: begin
`ifdef CHEBYSHEV_CLENSHAW_SAT_EN
        ovf_d = ovf_q | clip;
`endif
        if (k_q == '0) begin
          data_out_d  = res;
          out_valid_d = 1'b1;
          state_d     = DONE;
        end else begin
          b2_d = b1_q;
          b1_d = res;
          k_d  = k_q - AW'(1);
        end
      end
      DONE: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          in_ready_d  = 1'b1;
          state_d     = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clock) begin : regs
    if (reset) begin
      state_q     <= IDLE;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      data_out_q  <= '0;
      b1_q        <= '0;
      b2_q        <= '0;
      x_q         <= '0;
      k_q         <= '0;
      for (int i = 0; i < int'(NC); i++) begin
        bank_q[i] <= '0;
      end
`ifdef CHEBYSHEV_CLENSHAW_SAT_EN
      ovf_q       <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      data_out_q  <= data_out_d;
      b1_q        <= b1_d;
      b2_q        <= b2_d;
      x_q         <= x_d;
      k_q         <= k_d;
      bank_q      <= bank_d;
`ifdef CHEBYSHEV_CLENSHAW_SAT_EN
      ovf_q       <= ovf_d;
`endif
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign data_out  = data_out_q;
`ifdef CHEBYSHEV_CLENSHAW_SAT_EN
  assign ovf = ovf_q;
`else
  assign ovf = 1'b0;
`endif

endmodule
